// File: rtl/gated_clk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gated_clk_pkg
// Purpose  : Shared definitions for the clock-gating enable controller:
//            controller state encoding, parameter defaults and the
//            saturation value of the gating-event counter.
// Revision : 1.0 - initial release
// ============================================================================
package gated_clk_pkg;

  // Controller states. RUN: clock on and usable; GATED: clock stopped;
  // WAKE: clock re-enabled but still settling.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    GATED = 2'd1,
    WAKE  = 2'd2
  } state_t;

  localparam int CNT_W_DEFAULT    = 8;
  localparam int WAKE_DLY_DEFAULT = 2;

  localparam logic [15:0] GATE_CNT_MAX = 16'hFFFF;

endpackage : gated_clk_pkg
`default_nettype wire

// File: rtl/gated_clk_idle_cnt.sv
`default_nettype none
// ============================================================================
// Module   : gated_clk_idle_cnt
// Purpose  : Counts consecutive idle cycles while the controller is running
//            and flags the cycle on which gating may take place.
// Ports    : clk        - free-running clock
//            rst        - asynchronous active-high reset
//            count_en   - counting allowed (controller in RUN, no test mode);
//                         when low the count is held at zero
//            idle       - current cycle is idle (no busy, no wake request)
//            clear      - force the count back to zero on the next edge
//            limit      - idle threshold, 0 disables the threshold
//            limit_hit  - this idle cycle completes the threshold
// Revision : 1.0 - initial release
// ============================================================================
module gated_clk_idle_cnt
  import gated_clk_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             count_en,
  input  logic             idle,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic             limit_hit
);

  logic [CNT_W-1:0] idle_cnt;
  logic [CNT_W:0]   cnt_plus_one;

  // One extra bit so that a saturated count plus one cannot wrap.
  assign cnt_plus_one = {1'b0, idle_cnt} + {{CNT_W{1'b0}}, 1'b1};

  // The limit is compared live, so lowering it below the current count
  // fires on the very next idle cycle.
  assign limit_hit = count_en && idle && (limit != '0) &&
                     (cnt_plus_one >= {1'b0, limit});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (clear || !count_en) begin
      idle_cnt <= '0;
    end else if (idle) begin
      if (idle_cnt != {CNT_W{1'b1}}) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end else begin
      idle_cnt <= '0;
    end
  end

endmodule : gated_clk_idle_cnt
`default_nettype wire

// File: rtl/gated_clk_en_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gated_clk_en_ctrl
// Purpose  : Decides when the downstream clock may be stopped. After
//            idle_limit consecutive idle cycles the enable for the external
//            clock-gating cell is dropped; activity, a wake request or
//            disabling auto-gating re-enables it, and clk_ready follows after
//            WAKE_DLY settle cycles. Test mode forces the clock on.
// Ports    : clk_in           - free-running (ungated) clock
//            rst              - asynchronous active-high reset
//            busy             - downstream has work this cycle
//            wake_req         - external wake request
//            ctrl_en          - auto-gating permitted
//            idle_limit       - idle cycles before gating, 0 = never gate
//            pad_yy_test_mode - forces the clock on
//            local_en         - registered enable to the clock-gating cell
//            clk_ready        - gated clock stable and usable
//            gated            - clock currently stopped
//            gate_cnt         - saturating count of RUN->GATED transitions
// Revision : 1.0 - initial release
// ============================================================================
module gated_clk_en_ctrl
  import gated_clk_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEFAULT,
  parameter int WAKE_DLY = WAKE_DLY_DEFAULT
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             busy,
  input  logic             wake_req,
  input  logic             ctrl_en,
  input  logic [CNT_W-1:0] idle_limit,
  input  logic             pad_yy_test_mode,
  output logic             local_en,
  output logic             clk_ready,
  output logic             gated,
  output logic [15:0]      gate_cnt
);

  // Wake counter spans 0 .. WAKE_DLY-1; keep at least one bit so the
  // declaration stays legal when WAKE_DLY is 0 or 1.
  localparam int WCW = (WAKE_DLY > 1) ? $clog2(WAKE_DLY) : 1;
  localparam logic [WCW-1:0] WAKE_LAST = WCW'((WAKE_DLY > 0) ? (WAKE_DLY - 1) : 0);
  localparam bit DIRECT_WAKE = (WAKE_DLY == 0);

  state_t         state;
  logic [WCW-1:0] wake_cnt;

  logic idle;
  logic count_en;
  logic limit_hit;
  logic gate_go;
  logic wake_go;

  assign idle     = !busy && !wake_req;
  assign count_en = (state == RUN) && !pad_yy_test_mode;
  // limit_hit already implies RUN, idle and no test mode.
  assign gate_go  = ctrl_en && limit_hit;
  assign wake_go  = busy || wake_req || !ctrl_en;

  gated_clk_idle_cnt #(
    .CNT_W (CNT_W)
  ) u_idle_cnt (
    .clk       (clk_in),
    .rst       (rst),
    .count_en  (count_en),
    .idle      (idle),
    .clear     (gate_go),
    .limit     (idle_limit),
    .limit_hit (limit_hit)
  );

  // Single registered FSM: every output is assigned alongside the state it
  // belongs to, so nothing reaches an output without passing a flop.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      wake_cnt  <= '0;
      local_en  <= 1'b1;
      clk_ready <= 1'b1;
      gated     <= 1'b0;
      gate_cnt  <= '0;
    end else if (pad_yy_test_mode) begin
      // Test mode overrides everything, including an ongoing wake sequence.
      state     <= RUN;
      wake_cnt  <= '0;
      local_en  <= 1'b1;
      clk_ready <= 1'b1;
      gated     <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (gate_go) begin
            state     <= GATED;
            local_en  <= 1'b0;
            clk_ready <= 1'b0;
            gated     <= 1'b1;
            if (gate_cnt != GATE_CNT_MAX) begin
              gate_cnt <= gate_cnt + 16'd1;
            end
          end
        end

        GATED: begin
          if (wake_go) begin
            if (DIRECT_WAKE) begin
              state     <= RUN;
              local_en  <= 1'b1;
              clk_ready <= 1'b1;
              gated     <= 1'b0;
            end else begin
              state     <= WAKE;
              wake_cnt  <= '0;
              local_en  <= 1'b1;
              clk_ready <= 1'b0;
              gated     <= 1'b0;
            end
          end
        end

        WAKE: begin
          // busy / wake_req are irrelevant here; the settle time always
          // runs to completion.
          if (wake_cnt == WAKE_LAST) begin
            state     <= RUN;
            wake_cnt  <= '0;
            clk_ready <= 1'b1;
          end else begin
            wake_cnt <= wake_cnt + 1'b1;
          end
        end

        default: begin
          state     <= RUN;
          wake_cnt  <= '0;
          local_en  <= 1'b1;
          clk_ready <= 1'b1;
          gated     <= 1'b0;
        end
      endcase
    end
  end

endmodule : gated_clk_en_ctrl
`default_nettype wire

// File: doc/gated_clk_en_ctrl.md
GATED_CLK_EN_CTRL -- requirements
Module: gated_clk_en_ctrl

Interface
REQ-001 Parameter CNT_W, default 8: width of the idle counter and of idle_limit.
REQ-002 Parameter WAKE_DLY, default 2: settle cycles from local_en re-assert to clk_ready.
REQ-003 clk_in  input  1  free-running clock (ungated side); one clock only.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 busy  input  1  downstream module has work this cycle.
REQ-006 wake_req  input  1  external wake request, level or pulse.
REQ-007 ctrl_en  input  1  auto-gating permitted; 0 keeps the clock running.
REQ-008 idle_limit  input  CNT_W  consecutive idle cycles before gating; 0 disables gating.
REQ-009 pad_yy_test_mode  input  1  test mode; forces the clock on.
REQ-010 local_en  output  1  registered enable driving the gated clock cell local_en pin.
REQ-011 clk_ready  output  1  gated clock stable and usable by the downstream module.
REQ-012 gated  output  1  high while in GATED state.
REQ-013 gate_cnt  output  16  number of RUN->GATED transitions, saturating at 16'hFFFF.

Function
REQ-014 The FSM SHALL have exactly three states: RUN, GATED and WAKE.
REQ-015 In RUN: local_en=1, clk_ready=1, gated=0.
REQ-016 In GATED: local_en=0, clk_ready=0, gated=1.
REQ-017 In WAKE: local_en=1, clk_ready=0, gated=0.
REQ-018 All outputs SHALL be registered, with no combinational path from input to output.
REQ-019 Idle cycle = busy=0 and wake_req=0; in RUN the idle counter SHALL increment per idle cycle, saturate at all-ones, and clear on any non-idle cycle.
REQ-020 RUN->GATED SHALL occur on the edge sampling an idle cycle when ctrl_en=1, test_mode=0, idle_limit!=0, and idle_cnt+1 >= idle_limit.
REQ-021 On RUN->GATED, local_en SHALL be low after that edge; the idle counter SHALL clear.
REQ-022 idle_limit SHALL be compared live; lowering it mid-count below the count SHALL gate on the next idle cycle.
REQ-023 GATED->WAKE SHALL occur on the first edge sampling busy=1, wake_req=1 or ctrl_en=0; local_en SHALL be high after that edge.
REQ-024 WAKE SHALL last exactly WAKE_DLY cycles, counted by a wake counter, then go to RUN; clk_ready rises WAKE_DLY edges after local_en rises.
REQ-025 If WAKE_DLY=0, GATED SHALL go directly to RUN.
REQ-026 busy and wake_req in WAKE SHALL be ignored; no return to GATED from WAKE.
REQ-027 pad_yy_test_mode=1 SHALL force next state RUN from any state and hold the idle counter at 0; it overrides every other input.
REQ-028 If busy/wake_req arrive in the same cycle the threshold is met, the block SHALL stay in RUN and clear the counter.
REQ-029 gate_cnt SHALL increment by 1 on each RUN->GATED edge and hold at 16'hFFFF.

Reset
REQ-030 While rst=1: state=RUN, local_en=1, clk_ready=1, gated=0, gate_cnt=0, and both counters=0; the clock SHALL run out of reset.
REQ-031 Reset asserted in GATED or WAKE SHALL take effect immediately and asynchronously, with no wake sequence afterwards.

Structure
REQ-032 The shared package gated_clk_pkg SHALL hold the state enum (RUN, GATED, WAKE), the CNT_W default and the WAKE_DLY default.
REQ-033 The idle counter SHALL be the sub-module gated_clk_idle_cnt (count/clear/saturate/compare); the FSM, wake counter and gate_cnt stay in the top module.
REQ-034 local_en SHALL connect directly to the gated clock cell; this block SHALL NOT instantiate the gate itself.

Verification
REQ-035 Reset release, idle_limit=4, ctrl_en=1, busy=0 -> local_en low after the 4th edge, gated=1, gate_cnt=1.
REQ-036 In GATED, pulse wake_req for 1 cycle with WAKE_DLY=2 -> local_en=1 the next cycle, clk_ready=1 two edges later, state RUN.
REQ-037 idle_limit=4, busy drops for 3 cycles then rises on cycle 4 -> no gating, counter cleared, gate_cnt unchanged.
REQ-038 In GATED, assert pad_yy_test_mode -> RUN next edge, local_en=1 and clk_ready=1 with no WAKE; hold test mode for 20 idle cycles -> no gating.
REQ-039 Set idle_limit=0, or ctrl_en=0, with 300 idle cycles -> local_en stays 1; clear ctrl_en in GATED -> WAKE then RUN.
REQ-040 Assert rst mid-WAKE -> all outputs at reset values immediately; force gate_cnt to 16'hFFFE, then two gating events -> 16'hFFFF held.
